// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 16-bit shift/rotate unit for the execute stage.
// It applies one 4-bit step per cycle while at least 4 positions remain,
// then 1-bit steps, which trades latency for area against a barrel shifter.
// Step count is cnt[3:2] + cnt[1:0] (at most 6); done follows the last step.
//
// Build option: define SHIFT_SEQ_ROTATE_EN to implement ROL (op=00).
// Without it, op=00 passes the operand through with the same step timing.
//
// Ports:
//   clk    in   1   clock, rising edge
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   request, accepted when not busy (IDLE or DONE)
//   op     in   2   00 ROL, 01 SLL, 10 SRA, 11 SRL; latched on accept
//   in     in   16  operand; latched on accept
//   cnt    in   4   shift amount 0..15; latched on accept
//   busy   out  1   high while shifting
//   done   out  1   one-cycle pulse; out is valid in that cycle
//   out    out  16  result, held from done until the next completion
module shift_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] in,
  input  logic [3:0]  cnt,
  output logic        busy,
  output logic        done,
  output logic [15:0] out
);

  localparam int unsigned data_w = 16;
  localparam int unsigned cnt_w  = 4;

  localparam logic [1:0] op_rol = 2'b00;
  localparam logic [1:0] op_sll = 2'b01;
  localparam logic [1:0] op_sra = 2'b10;
  localparam logic [1:0] op_srl = 2'b11;

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_shift = 2'd1,
    st_done  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [data_w-1:0]   acc_q, acc_d;
  logic [cnt_w-1:0]    rem_q, rem_d;
  logic [1:0]          op_q, op_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [data_w-1:0]   out_q, out_d;
  logic                big_step;

  // One shift step of 4 (big) or 1 position according to the latched op.
  function automatic logic [data_w-1:0] step(input logic [data_w-1:0] a,
                                             input logic [1:0] o,
                                             input logic big);
    logic [data_w-1:0] r;
    r = a;
    case (o)
      op_sll: r = big ? {a[11:0], 4'b0000} : {a[14:0], 1'b0};
      op_srl: r = big ? {4'b0000, a[15:4]} : {1'b0, a[15:1]};
      op_sra: r = big ? {{4{a[15]}}, a[15:4]} : {a[15], a[15:1]};
      op_rol: begin
`ifdef SHIFT_SEQ_ROTATE_EN
        r = big ? {a[11:0], a[15:12]} : {a[14:0], a[15]};
`else
        r = a;
`endif
      end
      default: r = a;
    endcase
    return r;
  endfunction

  assign big_step = (rem_q >= cnt_w'(4));

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    op_d    = op_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    out_d   = out_q;

    case (state_q)
      st_idle, st_done: begin
        if (start) begin
          acc_d = in;
          rem_d = cnt;
          op_d  = op;
          if (cnt == '0) begin
            // Zero count completes immediately with the operand unchanged.
            state_d = st_done;
            done_d  = 1'b1;
            out_d   = in;
          end else begin
            state_d = st_shift;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = st_idle;
        end
      end

      st_shift: begin
        acc_d = step(acc_q, op_q, big_step);
        rem_d = rem_q - (big_step ? cnt_w'(4) : cnt_w'(1));
        if (rem_d == '0) begin
          state_d = st_done;
          done_d  = 1'b1;
          out_d   = acc_d;
        end else begin
          busy_d  = 1'b1;
        end
      end

      default: state_d = st_idle;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= st_idle;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule
